uart_rx_ctrl: RTL and testbench

Controller for the 16x-oversampling UART receiver. It generates the receiver's oversample enable (rx_enb) from a programmable clock divider and drains each completed byte through the receiver's rdy/rdy_clr handshake into a local FIFO. It also presents a first-word-fall-through read port and a sticky overrun flag to the CPU side. It sits between the receiver instance and the register/bus interface.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_rx_ctrl.sv | 115 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: drain FSM encoding and the
// receiver oversampling ratio.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } drain_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, occupancy count and
// registered full/empty flags. A push while full succeeds only with a pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;
    logic [CW-1:0]    count_d;

    // A pop frees the slot a simultaneous push needs, so full only blocks a lone push.
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);
    assign count_d   = count + CW'(push_ok_c) - CW'(pop_ok_c);

    assign rd_data = mem[rd_ptr];

    // Storage array carries no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick divider plus a drain FSM that
// moves each received byte through the rdy/rdy_clr handshake into a FIFO.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_en,
    input  logic [DIV_W-1:0]        div,
    output logic                    rx_enb,
    input  logic                    rcv_rdy,
    input  logic [7:0]              rcv_data,
    output logic                    rcv_rdy_clr,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] limit_c;
    logic             tick_d;

    drain_state_e     state_q;
    drain_state_e     state_d;
    logic             clr_d;
    logic             push_c;
    logic             drop_c;

    // Divider: div of 0 behaves as 1; an oversized count wraps without a tick.
    assign limit_c = (div == '0) ? DIV_W'(1) : div;

    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        tick_d = 1'b0;
        if (!rx_en) begin
            cnt_d = '0;
        end else if (cnt_q == limit_c - DIV_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else if (cnt_q >= limit_c) begin
            cnt_d = '0;
        end
    end

    // Drain FSM: capture once in IDLE, then hold the clear until rdy drops.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rcv_rdy) begin
                    push_c  = 1'b1;
                    clr_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (rcv_rdy) begin
                    clr_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A byte is lost only when full and no pop frees a slot this cycle.
    assign drop_c = push_c && full && !rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rx_enb      <= 1'b0;
            state_q     <= IDLE;
            rcv_rdy_clr <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_enb      <= tick_d;
            state_q     <= state_d;
            rcv_rdy_clr <= clr_d;
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .wr_data (rcv_data),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: divider, drain handshake,
// FIFO ordering, overrun and reset behaviour.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DIV_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rx_en;
    logic [DIV_W-1:0]        div;
    logic                    rx_enb;
    logic                    rcv_rdy;
    logic [7:0]              rcv_data;
    logic                    rcv_rdy_clr;
    logic                    rd_en;
    logic [7:0]              rd_data;
    logic                    empty;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;
    logic                    overrun;
    logic                    ovr_clr;

    int tests  = 0;
    int errors = 0;

    uart_rx_ctrl #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .div         (div),
        .rx_enb      (rx_enb),
        .rcv_rdy     (rcv_rdy),
        .rcv_data    (rcv_data),
        .rcv_rdy_clr (rcv_rdy_clr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: raise rdy, drop it the cycle after clr is seen.
    task automatic send_byte(input logic [7:0] d);
        int n;
        rcv_data = d;
        rcv_rdy  = 1'b1;
        n = 0;
        while (!rcv_rdy_clr && n < 8) begin
            tick();
            n++;
        end
        if (!rcv_rdy_clr) check("clr_rise_timeout", 32'(rcv_rdy_clr), 32'd1);
        tick();
        rcv_rdy = 1'b0;
        n = 0;
        while (rcv_rdy_clr && n < 8) begin
            tick();
            n++;
        end
        if (rcv_rdy_clr) check("clr_fall_timeout", 32'(rcv_rdy_clr), 32'd0);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_en    = 1'b0;
        div      = '0;
        rcv_rdy  = 1'b0;
        rcv_data = '0;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
        tick();
        tick();
        check("rst_rx_enb",  32'(rx_enb), 32'd0);
        check("rst_clr",     32'(rcv_rdy_clr), 32'd0);
        check("rst_empty",   32'(empty), 32'd1);
        check("rst_full",    32'(full), 32'd0);
        check("rst_count",   32'(count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // div=4: pulse on every 4th edge after rx_en rises
        div   = 16'd4;
        rx_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("div4_tick", 32'(rx_enb), ((k % 4) == 0) ? 32'd1 : 32'd0);
        end
        div = 16'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("div0_tick", 32'(rx_enb), 32'd1);
        end
        rx_en = 1'b0;
        tick();
        check("rx_en_off", 32'(rx_enb), 32'd0);

        // div shrinks below the running count: wrap silently, then tick at new limit
        div   = 16'd8;
        rx_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        div = 16'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("div_change", 32'(rx_enb), (k == 3) ? 32'd1 : 32'd0);
        end
        rx_en = 1'b0;
        tick();

        // Single byte with explicit handshake timing
        rcv_data = 8'hA5;
        rcv_rdy  = 1'b1;
        tick();
        check("sb_clr_n1",  32'(rcv_rdy_clr), 32'd1);
        check("sb_count",   32'(count), 32'd1);
        check("sb_rd_data", 32'(rd_data), 32'hA5);
        check("sb_empty",   32'(empty), 32'd0);
        tick();
        check("sb_clr_n2",  32'(rcv_rdy_clr), 32'd1);
        rcv_rdy = 1'b0;
        tick();
        check("sb_clr_n3",  32'(rcv_rdy_clr), 32'd0);
        check("sb_count_hold", 32'(count), 32'd1);
        pop_one();
        check("sb_pop_empty", 32'(empty), 32'd1);
        pop_one();
        check("pop_on_empty_count", 32'(count), 32'd0);
        check("pop_on_empty_flag",  32'(empty), 32'd1);

        // rdy held for 5 cycles: still a single push
        rcv_data = 8'h3C;
        rcv_rdy  = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rcv_rdy = 1'b0;
        tick();
        tick();
        check("held_count",   32'(count), 32'd1);
        check("held_rd_data", 32'(rd_data), 32'h3C);
        check("held_clr",     32'(rcv_rdy_clr), 32'd0);
        pop_one();

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("fill_full",  32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovr",   32'(overrun), 32'd0);
        send_byte(8'hFF);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_count",   32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(empty), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Push and pop on the same edge while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        rcv_data = 8'h55;
        rcv_rdy  = 1'b1;
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        check("simul_count",   32'(count), 32'd16);
        check("simul_full",    32'(full), 32'd1);
        check("simul_overrun", 32'(overrun), 32'd0);
        check("simul_head",    32'(rd_data), 32'h11);
        tick();
        rcv_rdy = 1'b0;
        tick();
        check("simul_clr", 32'(rcv_rdy_clr), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("simul_order", 32'(rd_data), (i < 15) ? 32'(8'h11 + i) : 32'h55);
            pop_one();
        end
        check("simul_empty", 32'(empty), 32'd1);

        // ovr_clr coinciding with a new overrun leaves the flag set
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        send_byte(8'hEE);
        check("ovr2_set", 32'(overrun), 32'd1);
        rcv_data = 8'hEF;
        rcv_rdy  = 1'b1;
        ovr_clr  = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr_vs_set", 32'(overrun), 32'd1);
        check("ovr_clr_count",  32'(count), 32'd16);
        tick();
        rcv_rdy = 1'b0;
        tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr_alone", 32'(overrun), 32'd0);
        check("ovr_head_kept", 32'(rd_data), 32'h20);

        // Reset while in CLEAR with three bytes queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_empty", 32'(empty), 32'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        rcv_data = 8'h03;
        rcv_rdy  = 1'b1;
        div      = 16'd0;
        rx_en    = 1'b1;
        tick();
        check("pre_rst_count",  32'(count), 32'd3);
        check("pre_rst_clr",    32'(rcv_rdy_clr), 32'd1);
        check("pre_rst_rx_enb", 32'(rx_enb), 32'd1);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rcv_rdy = 1'b0;
        rx_en   = 1'b0;
        check("mid_rst_count",  32'(count), 32'd0);
        check("mid_rst_empty",  32'(empty), 32'd1);
        check("mid_rst_clr",    32'(rcv_rdy_clr), 32'd0);
        check("mid_rst_rx_enb", 32'(rx_enb), 32'd0);
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
